linescanner_readout_sequencer: RTL

//  Sequencer for the line-scan sensor readout: drives sensor reset, load pulse and
//  the per-pixel rst_cvc -> rst_cds -> sample -> end_adc cycle. Captures one ADC byte
//  per pixel, tags it with its pixel index and line markers, and repeats lines while

---
 rtl/linescanner_readout_sequencer_if.sv | 38 +++
 rtl/linescanner_readout_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/linescanner_readout_sequencer_if.sv
// Sensor-side pins and pixel capture path of the line-scan readout sequencer.
// The sequencer takes the master view; the sensor/ADC model and the capture
// logic take the slave view.
interface linescanner_readout_sequencer_if #(
  parameter int PIXELS_PER_LINE = 1024
);
  localparam int IDX_W = $clog2(PIXELS_PER_LINE);

  logic             enable;
  logic             end_adc;
  logic [7:0]       data;
  logic             sensor_n_reset;
  logic             load_pulse;
  logic             rst_cvc;
  logic             rst_cds;
  logic             sample;
  logic [7:0]       pixel_data;
  logic             pixel_captured;
  logic [IDX_W-1:0] pixel_index;
  logic             line_start;
  logic             line_end;
  logic             busy;
  logic             adc_timeout;

  modport master (
    input  enable, end_adc, data,
    output sensor_n_reset, load_pulse, rst_cvc, rst_cds, sample,
           pixel_data, pixel_captured, pixel_index, line_start, line_end,
           busy, adc_timeout
  );

  modport slave (
    output enable, end_adc, data,
    input  sensor_n_reset, load_pulse, rst_cvc, rst_cds, sample,
           pixel_data, pixel_captured, pixel_index, line_start, line_end,
           busy, adc_timeout
  );
endinterface

// File: rtl/linescanner_readout_sequencer.sv
// Line-scan sensor readout sequencer: sensor reset, line load pulse and the
// per-pixel rst_cvc -> rst_cds -> sample -> ADC wait cycle, capturing one ADC
// byte per pixel tagged with its index and line markers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped, sensor held in reset, waiting for enable
// SRST  | sensor_n_reset low for SENSOR_RST_CYC cycles
// LOAD  | load_pulse high for LOAD_CYC cycles, pixel counter cleared
// CVC   | rst_cvc high for RST_CVC_CYC cycles
// CDS   | rst_cds high for RST_CDS_CYC cycles
// SMP   | sample high for SAMPLE_CYC cycles
// WADC  | waiting for end_adc, at most ADC_TIMEOUT cycles
// CAPT  | one-cycle pixel strobe, advance to next pixel or to GAP
// GAP   | LINE_GAP_CYC idle cycles, then next line (LOAD) or IDLE
module linescanner_readout_sequencer #(
  parameter int PIXELS_PER_LINE = 1024,
  parameter int SENSOR_RST_CYC  = 16,
  parameter int LOAD_CYC        = 4,
  parameter int RST_CVC_CYC     = 2,
  parameter int RST_CDS_CYC     = 2,
  parameter int SAMPLE_CYC      = 4,
  parameter int ADC_TIMEOUT     = 64,
  parameter int LINE_GAP_CYC    = 8
) (
  input logic                             main_clock_source,
  input logic                             n_reset,
  linescanner_readout_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(PIXELS_PER_LINE);

  // One shared down-counter times every phase, sized for the longest one.
  localparam int MAX_A   = (SENSOR_RST_CYC > LOAD_CYC)    ? SENSOR_RST_CYC : LOAD_CYC;
  localparam int MAX_B   = (RST_CVC_CYC > RST_CDS_CYC)    ? RST_CVC_CYC    : RST_CDS_CYC;
  localparam int MAX_C   = (SAMPLE_CYC > ADC_TIMEOUT)     ? SAMPLE_CYC     : ADC_TIMEOUT;
  localparam int MAX_AB  = (MAX_A > MAX_B)                ? MAX_A          : MAX_B;
  localparam int MAX_ABC = (MAX_AB > MAX_C)               ? MAX_AB         : MAX_C;
  localparam int TMR_MAX = (MAX_ABC > LINE_GAP_CYC)       ? MAX_ABC        : LINE_GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] T_SRST = TMR_W'(SENSOR_RST_CYC - 1);
  localparam logic [TMR_W-1:0] T_LOAD = TMR_W'(LOAD_CYC - 1);
  localparam logic [TMR_W-1:0] T_CVC  = TMR_W'(RST_CVC_CYC - 1);
  localparam logic [TMR_W-1:0] T_CDS  = TMR_W'(RST_CDS_CYC - 1);
  localparam logic [TMR_W-1:0] T_SMP  = TMR_W'(SAMPLE_CYC - 1);
  localparam logic [TMR_W-1:0] T_WADC = TMR_W'(ADC_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] T_GAP  = TMR_W'(LINE_GAP_CYC - 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_LINE - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_SRST = 4'd1;
  localparam logic [3:0] S_LOAD = 4'd2;
  localparam logic [3:0] S_CVC  = 4'd3;
  localparam logic [3:0] S_CDS  = 4'd4;
  localparam logic [3:0] S_SMP  = 4'd5;
  localparam logic [3:0] S_WADC = 4'd6;
  localparam logic [3:0] S_CAPT = 4'd7;
  localparam logic [3:0] S_GAP  = 4'd8;

  logic [3:0]       state;
  logic [TMR_W-1:0] tmr;
  logic [IDX_W-1:0] pix_cnt;
  logic [7:0]       pix_data_q;
  logic [IDX_W-1:0] pix_idx_q;
  logic             timeout_q;
  logic             enable_q;

  logic tmr_done;
  logic adc_done;
  logic adc_expired;

  assign tmr_done    = (tmr == '0);
  // end_adc only matters while waiting; anywhere else it is ignored.
  assign adc_done    = (state == S_WADC) && bus.end_adc;
  assign adc_expired = (state == S_WADC) && !bus.end_adc && tmr_done;

  // Phase sequencing: state, phase timer and pixel counter.
  always_ff @(posedge main_clock_source or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      tmr     <= '0;
      pix_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            state <= S_SRST;
            tmr   <= T_SRST;
          end
        end
        S_SRST: begin
          if (tmr_done) begin
            state   <= S_LOAD;
            tmr     <= T_LOAD;
            pix_cnt <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_LOAD: begin
          if (tmr_done) begin
            state <= S_CVC;
            tmr   <= T_CVC;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CVC: begin
          if (tmr_done) begin
            state <= S_CDS;
            tmr   <= T_CDS;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CDS: begin
          if (tmr_done) begin
            state <= S_SMP;
            tmr   <= T_SMP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_SMP: begin
          if (tmr_done) begin
            state <= S_WADC;
            tmr   <= T_WADC;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_WADC: begin
          if (adc_done || adc_expired) begin
            state <= S_CAPT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CAPT: begin
          if (pix_cnt == LAST_IDX) begin
            state <= S_GAP;
            tmr   <= T_GAP;
          end else begin
            state   <= S_CVC;
            tmr     <= T_CVC;
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (tmr_done) begin
            // A line is never cut short; enable is only looked at here.
            if (bus.enable) begin
              state   <= S_LOAD;
              tmr     <= T_LOAD;
              pix_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

  // Pixel capture registers and the sticky timeout flag.
  always_ff @(posedge main_clock_source or negedge n_reset) begin
    if (!n_reset) begin
      pix_data_q <= '0;
      pix_idx_q  <= '0;
      timeout_q  <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      enable_q <= bus.enable;
      if (adc_done) begin
        pix_data_q <= bus.data;
        pix_idx_q  <= pix_cnt;
      end else if (adc_expired) begin
        pix_data_q <= '0;
        pix_idx_q  <= pix_cnt;
      end
      // A fresh timeout outranks a simultaneous enable rising edge.
      if (adc_expired) begin
        timeout_q <= 1'b1;
      end else if (bus.enable && !enable_q) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign bus.sensor_n_reset = (state != S_IDLE) && (state != S_SRST);
  assign bus.load_pulse     = (state == S_LOAD);
  assign bus.rst_cvc        = (state == S_CVC);
  assign bus.rst_cds        = (state == S_CDS);
  assign bus.sample         = (state == S_SMP);
  assign bus.pixel_captured = (state == S_CAPT);
  assign bus.pixel_data     = pix_data_q;
  assign bus.pixel_index    = pix_idx_q;
  assign bus.line_start     = (state == S_CAPT) && (pix_idx_q == '0);
  assign bus.line_end       = (state == S_CAPT) && (pix_idx_q == LAST_IDX);
  assign bus.busy           = (state != S_IDLE);
  assign bus.adc_timeout    = timeout_q;

endmodule
